// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet/IPv4/UDP receive filter.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [3:0]  IP_VERSION_4   = 4'd4;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;

    localparam int unsigned ETH_HDR_LEN    = 14;
    localparam int unsigned IP_MIN_HDR_LEN = 20;
    localparam int unsigned UDP_HDR_LEN    = 8;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        IP_OPT,
        UDP_HDR,
        PAYLOAD,
        DRAIN
    } rx_state_t;

endpackage

// File: rtl/ip_csum_accum.sv
// IPv4 header checksum accumulator: 16-bit one's-complement sum with end-around carry.
module ip_csum_accum (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_clear,
    input  logic        i_add,
    input  logic [15:0] i_word,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;
    logic [16:0] w_add;
    logic [15:0] w_fold;

    // The folded carry can never overflow again: FFFF+FFFF folds to FFFF.
    assign w_add  = {1'b0, r_sum} + {1'b0, i_word};
    assign w_fold = w_add[15:0] + 16'(w_add[16]);
    assign o_sum  = r_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= w_fold;
        end
    end

endmodule

// File: rtl/eth_udp_rx_filter.sv
// UDP receive filter: validates Ethernet II / IPv4 / UDP headers from the RMII byte
// stream and forwards the payload of frames addressed to one of the configured ports.
module eth_udp_rx_filter
    import eth_pkg::*;
#(
    parameter logic [47:0]             FPGA_MAC     = 48'h001A2B3C4D5E,
    parameter logic [31:0]             FPGA_IP      = 32'hC0000292,
    parameter int unsigned             NUM_PORTS    = 2,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST    = {16'd5006, 16'd5005},
    parameter bit                      ACCEPT_BCAST = 1'b1,
    parameter int unsigned             COUNT_W      = 16,
    localparam int unsigned            IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               data_valid,
    input  logic [7:0]         received_byte,
    input  logic               byte_valid,
    output logic [7:0]         payload,
    output logic               payload_valid,
    output logic               payload_first,
    output logic               payload_last,
    output logic [IDX_W-1:0]   payload_port_idx,
    output logic               payload_abort,
    output logic [COUNT_W-1:0] rx_ok_count,
    output logic [COUNT_W-1:0] rx_drop_count
);

    rx_state_t        r_state, w_state_nxt;
    logic [5:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_prev;
    logic             r_fail, r_uni_ok, r_bc_ok, r_ip_ok, r_first;
    logic [3:0]       r_ihl;
    logic [15:0]      r_dport, r_udp_len, r_remaining;
    logic [15:0]      w_csum;
    logic [7:0]       w_mac_byte, w_ip_byte;
    logic [5:0]       w_opt_last;
    logic             w_port_hit;
    logic [IDX_W-1:0] w_port_idx;
    logic             w_byte, w_uni_match, w_bc_match, w_ip_match, w_reject;
    logic             w_drop, w_ok, w_abort, w_beat, w_last, w_accept;

    assign w_byte      = data_valid & byte_valid;
    assign w_uni_match = r_uni_ok && (received_byte == w_mac_byte);
    assign w_bc_match  = r_bc_ok && (received_byte == BCAST_MAC[7:0]);
    assign w_ip_match  = r_ip_ok && (received_byte == w_ip_byte);
    assign w_opt_last  = 6'({r_ihl - 4'd5, 2'b00}) - 6'd1;
    assign w_reject    = r_fail | (w_csum != 16'hFFFF) | ~w_port_hit
                       | (r_udp_len < 16'(UDP_HDR_LEN));

    ip_csum_accum u_csum (
        .clk    (clk),
        .resetn (resetn),
        .i_clear(r_state == PREAMBLE),
        .i_add  (w_byte && (r_state == IP_HDR || r_state == IP_OPT) && r_cnt[0]),
        .i_word ({r_prev, received_byte}),
        .o_sum  (w_csum)
    );

    // Expected address bytes, most significant first, indexed by header offset.
    always_comb begin
        w_mac_byte = 8'h00;
        w_ip_byte  = 8'h00;
        case (r_cnt[2:0])
            3'd0:    w_mac_byte = FPGA_MAC[47:40];
            3'd1:    w_mac_byte = FPGA_MAC[39:32];
            3'd2:    w_mac_byte = FPGA_MAC[31:24];
            3'd3:    w_mac_byte = FPGA_MAC[23:16];
            3'd4:    w_mac_byte = FPGA_MAC[15:8];
            3'd5:    w_mac_byte = FPGA_MAC[7:0];
            default: w_mac_byte = 8'h00;
        endcase
        case (r_cnt[1:0])
            2'd0:    w_ip_byte = FPGA_IP[31:24];
            2'd1:    w_ip_byte = FPGA_IP[23:16];
            2'd2:    w_ip_byte = FPGA_IP[15:8];
            default: w_ip_byte = FPGA_IP[7:0];
        endcase
    end

    // Lowest matching table index wins.
    always_comb begin
        w_port_hit = 1'b0;
        w_port_idx = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (PORT_LIST[16*i +: 16] == r_dport) begin
                w_port_hit = 1'b1;
                w_port_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drop      = 1'b0;
        w_ok        = 1'b0;
        w_abort     = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        w_accept    = 1'b0;
        if (!data_valid) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_abort     = (r_state == PAYLOAD);
            w_drop      = r_state inside {ETH_HDR, IP_HDR, IP_OPT, UDP_HDR};
        end else if (byte_valid) begin
            w_cnt_nxt = r_cnt + 6'd1;
            case (r_state)
                IDLE: if (received_byte == PREAMBLE_BYTE) w_state_nxt = PREAMBLE;
                PREAMBLE: begin
                    if (received_byte == SFD_BYTE) begin
                        w_state_nxt = ETH_HDR;
                        w_cnt_nxt   = '0;
                    end else if (received_byte != PREAMBLE_BYTE) begin
                        w_state_nxt = DRAIN;
                    end
                end
                ETH_HDR: if (r_cnt == 6'(ETH_HDR_LEN - 1)) begin
                    w_state_nxt = IP_HDR;
                    w_cnt_nxt   = '0;
                end
                IP_HDR: if (r_cnt == 6'(IP_MIN_HDR_LEN - 1)) begin
                    w_state_nxt = (r_ihl > 4'd5) ? IP_OPT : UDP_HDR;
                    w_cnt_nxt   = '0;
                end
                IP_OPT: if (r_cnt == w_opt_last) begin
                    w_state_nxt = UDP_HDR;
                    w_cnt_nxt   = '0;
                end
                UDP_HDR: if (r_cnt == 6'(UDP_HDR_LEN - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_reject) begin
                        w_state_nxt = DRAIN;
                        w_drop      = 1'b1;
                    end else if (r_udp_len == 16'(UDP_HDR_LEN)) begin
                        w_state_nxt = DRAIN;
                        w_ok        = 1'b1;
                    end else begin
                        w_state_nxt = PAYLOAD;
                        w_accept    = 1'b1;
                    end
                end
                PAYLOAD: begin
                    w_beat = 1'b1;
                    if (r_remaining == 16'd1) begin
                        w_last      = 1'b1;
                        w_ok        = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
                DRAIN:   w_state_nxt = DRAIN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Header field capture; each check folds into r_fail as soon as its last byte arrives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev    <= '0;
            r_fail    <= 1'b0;
            r_uni_ok  <= 1'b0;
            r_bc_ok   <= 1'b0;
            r_ip_ok   <= 1'b0;
            r_ihl     <= '0;
            r_dport   <= '0;
            r_udp_len <= '0;
        end else if (w_byte) begin
            r_prev <= received_byte;
            case (r_state)
                PREAMBLE: begin
                    r_fail   <= 1'b0;
                    r_uni_ok <= 1'b1;
                    r_bc_ok  <= 1'b1;
                    r_ip_ok  <= 1'b1;
                end
                ETH_HDR: begin
                    if (r_cnt < 6'd6) begin
                        r_uni_ok <= w_uni_match;
                        r_bc_ok  <= w_bc_match;
                    end
                    if (r_cnt == 6'd5 && !(w_uni_match || (ACCEPT_BCAST && w_bc_match)))
                        r_fail <= 1'b1;
                    if (r_cnt == 6'd13 && {r_prev, received_byte} != ETHERTYPE_IPV4)
                        r_fail <= 1'b1;
                end
                IP_HDR: begin
                    if (r_cnt == 6'd0) begin
                        r_ihl <= received_byte[3:0];
                        if (received_byte[7:4] != IP_VERSION_4 || received_byte[3:0] < 4'd5)
                            r_fail <= 1'b1;
                    end
                    if (r_cnt == 6'd9 && received_byte != IP_PROTO_UDP) r_fail <= 1'b1;
                    if (r_cnt >= 6'd16) r_ip_ok <= w_ip_match;
                    if (r_cnt == 6'd19 && !w_ip_match) r_fail <= 1'b1;
                end
                UDP_HDR: begin
                    if (r_cnt == 6'd3) r_dport   <= {r_prev, received_byte};
                    if (r_cnt == 6'd5) r_udp_len <= {r_prev, received_byte};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload          <= '0;
            payload_valid    <= 1'b0;
            payload_first    <= 1'b0;
            payload_last     <= 1'b0;
            payload_port_idx <= '0;
            payload_abort    <= 1'b0;
            rx_ok_count      <= '0;
            rx_drop_count    <= '0;
            r_remaining      <= '0;
            r_first          <= 1'b0;
        end else begin
            payload_valid <= w_beat;
            payload_first <= w_beat & r_first;
            payload_last  <= w_last;
            payload_abort <= w_abort;
            if (w_beat) payload <= received_byte;
            if (w_accept) begin
                payload_port_idx <= w_port_idx;
                r_remaining      <= r_udp_len - 16'(UDP_HDR_LEN);
                r_first          <= 1'b1;
            end else if (w_beat) begin
                r_remaining <= r_remaining - 16'd1;
                r_first     <= 1'b0;
            end
            if (w_ok && rx_ok_count != '1)     rx_ok_count   <= rx_ok_count + COUNT_W'(1);
            if (w_drop && rx_drop_count != '1) rx_drop_count <= rx_drop_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_eth_udp_rx_filter.sv
// Directed bench for eth_udp_rx_filter; a second instance with broadcast disabled shares the stimulus.
module tb_eth_udp_rx_filter;

    localparam logic [47:0] MAC_OK = 48'h001A2B3C4D5E;
    localparam logic [47:0] MAC_BC = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] IP_OK  = 32'hC0000292;
    localparam logic [15:0] P5005  = 16'h138D;
    localparam logic [15:0] P5006  = 16'h138E;
    localparam logic [15:0] P8001  = 16'h1F41;
    localparam logic [31:0] PL     = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        data_valid = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  received_byte = 8'h00;

    logic [7:0]  payload, nb_payload;
    logic        payload_valid, payload_first, payload_last, payload_abort;
    logic        nb_valid, nb_first, nb_last, nb_abort;
    logic [0:0]  payload_port_idx, nb_idx;
    logic [15:0] rx_ok_count, rx_drop_count, nb_ok, nb_drop;

    always #10 clk = ~clk;

    eth_udp_rx_filter u_dut (
        .clk(clk), .resetn(resetn), .data_valid(data_valid), .received_byte(received_byte),
        .byte_valid(byte_valid), .payload(payload), .payload_valid(payload_valid),
        .payload_first(payload_first), .payload_last(payload_last),
        .payload_port_idx(payload_port_idx), .payload_abort(payload_abort),
        .rx_ok_count(rx_ok_count), .rx_drop_count(rx_drop_count)
    );

    eth_udp_rx_filter #(.ACCEPT_BCAST(1'b0)) u_dut_nb (
        .clk(clk), .resetn(resetn), .data_valid(data_valid), .received_byte(received_byte),
        .byte_valid(byte_valid), .payload(nb_payload), .payload_valid(nb_valid),
        .payload_first(nb_first), .payload_last(nb_last),
        .payload_port_idx(nb_idx), .payload_abort(nb_abort),
        .rx_ok_count(nb_ok), .rx_drop_count(nb_drop)
    );

    int checks = 0;
    int failures = 0;
    int lat_err = 0;
    int flag_err = 0;
    int abort_cnt = 0;
    int nb_beats = 0;
    logic prev_bv = 1'b0;
    logic [7:0] frm[$];
    logic [7:0] beat_q[$];
    logic       first_q[$];
    logic       last_q[$];
    logic [0:0] idx_q[$];

    // Beat collector: a beat must follow a cycle in which byte_valid was presented.
    always @(negedge clk) begin
        if (payload_valid) begin
            beat_q.push_back(payload);
            first_q.push_back(payload_first);
            last_q.push_back(payload_last);
            idx_q.push_back(payload_port_idx);
            if (!prev_bv) lat_err++;
        end
        if ((payload_first || payload_last) && !payload_valid) flag_err++;
        if (payload_abort) abort_cnt++;
        if (nb_valid) nb_beats++;
        prev_bv = byte_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] pl,
                               input logic [0:0] idx);
        for (int i = 0; i < n; i++) begin
            if (beat_q.size() == 0) break;
            chk($sformatf("%s_byte%0d", tag, i), 32'(beat_q.pop_front()), 32'(8'(pl >> (24 - 8*i))));
            chk($sformatf("%s_first%0d", tag, i), 32'(first_q.pop_front()), 32'(i == 0));
            chk($sformatf("%s_last%0d", tag, i), 32'(last_q.pop_front()), 32'(i == n - 1));
            chk($sformatf("%s_idx%0d", tag, i), 32'(idx_q.pop_front()), 32'(idx));
        end
    endtask

    task automatic clear_beats();
        beat_q.delete();
        first_q.delete();
        last_q.delete();
        idx_q.delete();
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] etype, input logic [7:0] ver_ihl,
                         input logic [15:0] tot_len, input logic [7:0] proto, input logic [15:0] csum,
                         input logic [31:0] dip, input int nopt, input logic [15:0] dport,
                         input logic [15:0] ulen, input logic [31:0] pl, input int npl);
        logic [31:0] sip;
        sip = 32'hC0A80002;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(mac[8*i +: 8]);
        for (int i = 0; i < 5; i++) frm.push_back(8'h02);
        frm.push_back(8'h01);
        frm.push_back(etype[15:8]);  frm.push_back(etype[7:0]);
        frm.push_back(ver_ihl);      frm.push_back(8'h00);
        frm.push_back(tot_len[15:8]); frm.push_back(tot_len[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto);
        frm.push_back(csum[15:8]);   frm.push_back(csum[7:0]);
        for (int i = 3; i >= 0; i--) frm.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[8*i +: 8]);
        for (int i = 0; i < nopt; i++) frm.push_back(8'h00);
        frm.push_back(8'h12); frm.push_back(8'h34);
        frm.push_back(dport[15:8]);  frm.push_back(dport[7:0]);
        frm.push_back(ulen[15:8]);   frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < npl; i++) frm.push_back(8'(pl >> (24 - 8*i)));
        frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33); frm.push_back(8'h44);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        received_byte = b;
        byte_valid    = 1'b1;
        @(posedge clk); #1;
        byte_valid    = 1'b0;
    endtask

    // gap=0 leaves exactly one clock with data_valid low before the next frame.
    task automatic send_frame(input int nbytes, input int gap);
        @(posedge clk); #1;
        data_valid = 1'b1;
        for (int i = 0; i < nbytes; i++) send_byte(frm[i]);
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(payload_valid), 0);
        chk("rst_payload", 32'(payload), 0);
        chk("rst_first_last", 32'({payload_first, payload_last}), 0);
        chk("rst_idx_abort", 32'({payload_port_idx, payload_abort}), 0);
        chk("rst_ok", 32'(rx_ok_count), 0);
        chk("rst_drop", 32'(rx_drop_count), 0);
        resetn = 1'b1;

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("uni_nbeats", 32'(beat_q.size()), 4);
        check_beats("uni", 4, PL, 1'b0);
        chk("uni_ok", 32'(rx_ok_count), 1);
        chk("uni_nb_ok", 32'(nb_ok), 1);

        build(MAC_BC, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5006, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("bc_nbeats", 32'(beat_q.size()), 4);
        check_beats("bc", 4, PL, 1'b1);
        chk("bc_ok", 32'(rx_ok_count), 2);
        chk("bc_nb_drop", 32'(nb_drop), 1);
        chk("bc_nb_beats", 32'(nb_beats), 4);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB791, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("csum_nbeats", 32'(beat_q.size()), 0);
        chk("csum_drop", 32'(rx_drop_count), 1);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h06, 16'hB79B, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("proto_nbeats", 32'(beat_q.size()), 0);
        chk("proto_drop", 32'(rx_drop_count), 2);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, 32'hC0AA0292, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("dip_nbeats", 32'(beat_q.size()), 0);
        chk("dip_drop", 32'(rx_drop_count), 3);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P8001, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("port_nbeats", 32'(beat_q.size()), 0);
        chk("port_drop", 32'(rx_drop_count), 4);

        build(MAC_OK, 16'h86DD, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("etype_nbeats", 32'(beat_q.size()), 0);
        chk("etype_drop", 32'(rx_drop_count), 5);

        // IHL=6: 4600+0024 raise the header sum by 0x104, so the checksum becomes B68C.
        build(MAC_OK, 16'h0800, 8'h46, 16'h0024, 8'h11, 16'hB68C, IP_OK, 4, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("opt_nbeats", 32'(beat_q.size()), 4);
        check_beats("opt", 4, PL, 1'b0);
        chk("opt_ok", 32'(rx_ok_count), 3);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(52, 3);
        chk("abort_nbeats", 32'(beat_q.size()), 2);
        chk("abort_byte0", 32'(beat_q[0]), 32'hDE);
        chk("abort_byte1", 32'(beat_q[1]), 32'hAD);
        chk("abort_first0", 32'(first_q[0]), 1);
        chk("abort_last1", 32'(last_q[1]), 0);
        chk("abort_pulses", 32'(abort_cnt), 1);
        chk("abort_ok", 32'(rx_ok_count), 3);
        chk("abort_drop", 32'(rx_drop_count), 5);
        clear_beats();

        send_frame(frm.size(), 3);
        chk("after_abort_nbeats", 32'(beat_q.size()), 4);
        check_beats("after_abort", 4, PL, 1'b0);
        chk("after_abort_ok", 32'(rx_ok_count), 4);

        send_frame(frm.size(), 0);
        send_frame(frm.size(), 3);
        chk("b2b_nbeats", 32'(beat_q.size()), 8);
        check_beats("b2b_a", 4, PL, 1'b0);
        check_beats("b2b_b", 4, PL, 1'b0);
        chk("b2b_ok", 32'(rx_ok_count), 6);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd8, PL, 0);
        send_frame(frm.size(), 3);
        chk("len8_nbeats", 32'(beat_q.size()), 0);
        chk("len8_ok", 32'(rx_ok_count), 7);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5006, 16'd9, 32'hAB000000, 1);
        send_frame(frm.size(), 3);
        chk("len9_nbeats", 32'(beat_q.size()), 1);
        check_beats("len9", 1, 32'hAB000000, 1'b1);
        chk("len9_ok", 32'(rx_ok_count), 8);

        build(MAC_OK, 16'h0800, 8'h44, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(frm.size(), 3);
        chk("ihl4_nbeats", 32'(beat_q.size()), 0);
        chk("ihl4_drop", 32'(rx_drop_count), 6);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        send_frame(30, 3);
        chk("trunc_drop", 32'(rx_drop_count), 7);
        chk("trunc_ok", 32'(rx_ok_count), 8);

        frm.delete();
        frm.push_back(8'h55); frm.push_back(8'h55); frm.push_back(8'h55); frm.push_back(8'hAA);
        frm.push_back(8'h55); frm.push_back(8'hD5); frm.push_back(8'h00); frm.push_back(8'h1A);
        send_frame(frm.size(), 3);
        chk("nosfd_drop", 32'(rx_drop_count), 7);
        chk("nosfd_nbeats", 32'(beat_q.size()), 0);
        chk("latency", 32'(lat_err), 0);
        chk("flag_qual", 32'(flag_err), 0);
        chk("abort_total", 32'(abort_cnt), 1);

        build(MAC_OK, 16'h0800, 8'h45, 16'h0020, 8'h11, 16'hB790, IP_OK, 0, P5005, 16'd12, PL, 4);
        @(posedge clk); #1;
        data_valid = 1'b1;
        for (int i = 0; i < 51; i++) send_byte(frm[i]);
        chk("mid_valid", 32'(payload_valid), 1);
        chk("mid_payload", 32'(payload), 32'hDE);
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(payload_valid), 0);
        chk("arst_payload", 32'(payload), 0);
        chk("arst_first_last", 32'({payload_first, payload_last}), 0);
        chk("arst_ok", 32'(rx_ok_count), 0);
        chk("arst_drop", 32'(rx_drop_count), 0);
        data_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
